// File: rtl/scan_disp_ctl_pkg.sv
// rtl/scan_disp_ctl_pkg.sv - scan controller state encoding and seven-segment table
package scan_disp_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    localparam int CNT_W   = 16;
    localparam int NUM_DIG = 8;

    // Segment patterns, bit0 = a .. bit6 = g; 10-15 render as A b C d E F
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - combinational 4-bit code to seven-segment decoder
module seg7_dec
    import scan_disp_ctl_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7_TABLE[i_code];

endmodule

// File: rtl/scan_disp_ctl.sv
// rtl/scan_disp_ctl.sv - 8-digit multiplexed seven-segment scan controller with ghost blanking
module scan_disp_ctl
    import scan_disp_ctl_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] dig_val,
    input  logic [7:0]  dp_in,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp_out,
    output logic [7:0]  com,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] DRIVE_LOAD = 16'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = 16'(BLANK_CYC - 1);

    scan_state_t      r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_snap_dig;
    logic [7:0]       r_snap_dp;
    logic             r_snap_lz;
    logic [6:0]       r_seg;
    logic             r_dp_out;
    logic [7:0]       r_com;

    scan_state_t      w_nxt_state;
    logic [2:0]       w_nxt_idx;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_snap_load;
    logic             w_frame_done;
    logic [31:0]      w_snap_dig;
    logic [7:0]       w_snap_dp;
    logic             w_snap_lz;
    logic [3:0]       w_code;
    logic [6:0]       w_dec_seg;
    logic [7:0]       w_lz_mask;
    logic             w_lz_blank;
    logic [6:0]       w_nxt_seg;
    logic             w_nxt_dp;
    logic [7:0]       w_nxt_com;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_idx    = r_idx;
        w_nxt_cnt    = r_cnt;
        w_snap_load  = 1'b0;
        w_frame_done = 1'b0;
        if (!enable) begin
            w_nxt_state = ST_IDLE;
            w_nxt_idx   = 3'd0;
            w_nxt_cnt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = ST_DRIVE;
                    w_nxt_idx   = 3'd0;
                    w_nxt_cnt   = DRIVE_LOAD;
                    w_snap_load = 1'b1;
                end
                ST_DRIVE: begin
                    if (r_cnt == '0) begin
                        w_nxt_state = ST_BLANK;
                        w_nxt_cnt   = BLANK_LOAD;
                    end else begin
                        w_nxt_cnt = r_cnt - 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == '0) begin
                        w_nxt_state = ST_DRIVE;
                        w_nxt_idx   = r_idx + 3'd1;
                        w_nxt_cnt   = DRIVE_LOAD;
                        // Wrapping back to digit 0 is the only point a frame may pick up new data
                        if (r_idx == 3'd7) begin
                            w_snap_load  = 1'b1;
                            w_frame_done = 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_idx   = 3'd0;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

    assign w_snap_dig = w_snap_load ? dig_val : r_snap_dig;
    assign w_snap_dp  = w_snap_load ? dp_in   : r_snap_dp;
    assign w_snap_lz  = w_snap_load ? lz_en   : r_snap_lz;
    assign w_code     = w_snap_dig[{w_nxt_idx, 2'b00} +: 4];

    seg7_dec u_seg7_dec (
        .i_code (w_code),
        .o_seg  (w_dec_seg)
    );

    // Digit k is a leading zero when it and every higher digit are zero; digit 0 always shows
    always_comb begin : lz_scan
        logic v_all_zero;
        v_all_zero = 1'b1;
        w_lz_mask  = 8'h00;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            v_all_zero   = v_all_zero & (w_snap_dig[4*k +: 4] == 4'd0);
            w_lz_mask[k] = v_all_zero;
        end
    end

    assign w_lz_blank = w_snap_lz & w_lz_mask[w_nxt_idx];

    always_comb begin
        w_nxt_com = 8'hFF;
        w_nxt_seg = 7'd0;
        w_nxt_dp  = 1'b0;
        if (w_nxt_state == ST_DRIVE) begin
            w_nxt_com = ~(8'd1 << w_nxt_idx);
            w_nxt_seg = w_lz_blank ? 7'd0 : w_dec_seg;
            w_nxt_dp  = w_snap_dp[w_nxt_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_snap_dig <= 32'd0;
            r_snap_dp  <= 8'd0;
            r_snap_lz  <= 1'b0;
            r_seg      <= 7'd0;
            r_dp_out   <= 1'b0;
            r_com      <= 8'hFF;
        end else begin
            r_state    <= w_nxt_state;
            r_idx      <= w_nxt_idx;
            r_cnt      <= w_nxt_cnt;
            r_snap_dig <= w_snap_dig;
            r_snap_dp  <= w_snap_dp;
            r_snap_lz  <= w_snap_lz;
            r_seg      <= w_nxt_seg;
            r_dp_out   <= w_nxt_dp;
            r_com      <= w_nxt_com;
        end
    end

    assign seg        = r_seg;
    assign dp_out     = r_dp_out;
    assign com        = r_com;
    assign frame_done = w_frame_done;

endmodule

// File: tb/tb_scan_disp_ctl.sv
// tb/tb_scan_disp_ctl.sv - scoreboard bench for scan_disp_ctl with SCAN_DIV=8, BLANK_CYC=2
module tb_scan_disp_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] dig_val;
    logic [7:0]  dp_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp_out;
    logic [7:0]  com;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;

    typedef struct {
        logic [7:0] com;
        logic [6:0] seg;
        logic       dp;
        int         len;
        int         gap;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic have_cur = 1'b0;
    logic [7:0] prev_com = 8'hFF;
    int run = 0;
    int ff_run = 0;

    localparam logic [6:0] TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    scan_disp_ctl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dig_val    (dig_val),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp_out     (dp_out),
        .com        (com),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [31:0] d, input int i, input logic lz);
        logic all_zero;
        all_zero = 1'b1;
        if (lz && i > 0) begin
            for (int k = 7; k >= i; k--)
                if (d[4*k +: 4] != 4'd0) all_zero = 1'b0;
            if (all_zero) return 7'd0;
        end
        return TBL[d[4*i +: 4]];
    endfunction

    task automatic start_frame(input logic [31:0] d, input logic [7:0] p, input logic lz,
                               input int gap0, input int nslots, input int last_len);
        dig_val = d;
        dp_in   = p;
        lz_en   = lz;
        for (int i = 0; i < nslots; i++) begin
            exp_t e;
            e.com = 8'hFF ^ (8'd1 << i);
            e.seg = exp_seg(d, i, lz);
            e.dp  = p[i];
            e.len = (i == nslots - 1) ? last_len : 6;
            e.gap = (i == 0) ? gap0 : 2;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (com !== 8'hFF) begin
            if (prev_com === 8'hFF) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_slot: got com %0h expected none at %0t", com, $time);
                    have_cur = 1'b0;
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    check("slot_com", {24'd0, com}, {24'd0, cur.com});
                    check("slot_seg", {25'd0, seg}, {25'd0, cur.seg});
                    check("slot_dp", {31'd0, dp_out}, {31'd0, cur.dp});
                    if (cur.gap != 0) check("blank_len", ff_run, cur.gap);
                end
                run = 0;
            end else if (have_cur) begin
                check("slot_hold", {16'd0, com, seg, dp_out}, {16'd0, cur.com, cur.seg, cur.dp});
            end
            run++;
            ff_run = 0;
        end else begin
            if (prev_com !== 8'hFF && have_cur) begin
                check("drive_len", run, cur.len);
                check("blank_out", {24'd0, seg, dp_out}, 32'd0);
                have_cur = 1'b0;
            end
            ff_run++;
        end
        prev_com = com;
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        dig_val = 32'd0;
        dp_in   = 8'd0;
        lz_en   = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_com", {24'd0, com}, 32'hFF);
        check("rst_seg", {25'd0, seg}, 32'd0);
        check("rst_dp", {31'd0, dp_out}, 32'd0);
        check("rst_fd", {31'd0, frame_done}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_com", {24'd0, com}, 32'hFF);

        // Frames A-D: counting digits, rotating dp, mid-frame data change in frame C
        enable = 1'b1;
        start_frame(32'h76543210, 8'h01, 1'b0, 0, 8, 6);
        repeat (64) @(negedge clk);
        start_frame(32'h76543210, 8'h02, 1'b0, 2, 8, 6);
        repeat (64) @(negedge clk);
        start_frame(32'h76543210, 8'h04, 1'b0, 2, 8, 6);
        repeat (26) @(negedge clk);
        dig_val = 32'h89ABCDEF;
        repeat (38) @(negedge clk);
        start_frame(32'h89ABCDEF, 8'h08, 1'b0, 2, 8, 6);
        repeat (64) @(negedge clk);

        // Frame E: leading-zero blanking, dp kept on a blanked digit
        start_frame(32'h00000050, 8'h80, 1'b1, 2, 8, 6);
        repeat (32) @(negedge clk);
        check("fd_after_4", fd_cnt, 4);
        repeat (32) @(negedge clk);

        // Frame F: enable dropped during DRIVE of digit 5
        start_frame(32'h12345678, 8'h00, 1'b0, 2, 6, 2);
        repeat (42) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("drop_com", {24'd0, com}, 32'hFF);
        check("drop_seg", {25'd0, seg}, 32'd0);
        repeat (5) @(negedge clk);
        check("fd_after_drop", fd_cnt, 5);

        // Frame G: restart from index 0 with fresh snapshot
        enable = 1'b1;
        start_frame(32'h0000ABCD, 8'h10, 1'b1, 0, 8, 6);
        @(negedge clk);
        check("reen_com", {24'd0, com}, 32'hFE);
        repeat (63) @(negedge clk);

        // Frame H: asynchronous reset during BLANK of digit 2
        start_frame(32'h76543210, 8'h00, 1'b0, 2, 3, 6);
        repeat (23) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_com", {24'd0, com}, 32'hFF);
        check("mid_rst_seg", {25'd0, seg, dp_out}, 32'd0);
        check("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        check("mid_rst_q", q.size(), 0);

        // Frame I: scan resumes at index 0 after release; digit 0 never blanked
        start_frame(32'h00000000, 8'h01, 1'b1, 0, 8, 6);
        @(negedge clk);
        #4 reset = 1'b1;
        repeat (63) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("final_q", q.size(), 0);
        check("final_fd", fd_cnt, 6);
        check("final_com", {24'd0, com}, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_disp_ctl.md
SCAN_DISP_CTL -- requirements
Module: scan_disp_ctl

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles per digit slot (drive plus blank); legal range BLANK_CYC+2 to 65535.
REQ-002 Parameter BLANK_CYC, default 16, clk cycles of all-digits-off ghost blanking at the end of each slot; minimum 1.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = scan running, 0 = display dark.
REQ-006 dig_val  input  32  eight 4-bit digit codes; digit i is bits [4i+3:4i].
REQ-007 dp_in  input  8  decimal-point request per digit, fed by the dp rotation logic.
REQ-008 lz_en  input  1  1 = leading-zero blanking on.
REQ-009 seg  output  7  segments a..g (bit0=a), active-high, registered.
REQ-010 dp_out  output  1  decimal point for the active digit, active-high, registered.
REQ-011 com  output  8  digit commons, active-low one-hot, registered.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each full 8-digit frame.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DRIVE and BLANK.
REQ-014 IDLE SHALL drive com=8'hFF, seg=0, dp_out=0 and digit index=0.
REQ-015 IDLE->DRIVE SHALL occur on the first clk edge with enable=1; the same edge SHALL snapshot dig_val, dp_in and lz_en.
REQ-016 DRIVE for index i SHALL last SCAN_DIV-BLANK_CYC cycles, with com[i]=0 and all other com bits 1 from the first DRIVE cycle.
REQ-017 During DRIVE, seg SHALL carry the decoded snapshot digit i and dp_out SHALL equal snapshot dp[i].
REQ-018 BLANK SHALL last BLANK_CYC cycles with com=8'hFF, seg=0 and dp_out=0.
REQ-019 On leaving BLANK, the index SHALL advance i->i+1, wrapping 7->0; the FSM SHALL then re-enter DRIVE.
REQ-020 The snapshot SHALL be refreshed only on entry to DRIVE for index 0, so no frame mixes old and new data.
REQ-021 frame_done SHALL pulse 1 in the cycle the FSM leaves BLANK of index 7.
REQ-022 Decode SHALL map codes 0-9 to standard digits and 10-15 to hex A,b,C,d,E,F.
REQ-023 With snapshot lz_en=1, digit k (k=7..1) SHALL be blanked (seg=0) when its code and all higher digit codes are 0.
REQ-024 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-025 dp_out SHALL still follow dp[k] on a leading-zero-blanked digit.
REQ-026 enable=0 in any state SHALL force IDLE on the next edge, with no frame_done pulse.
REQ-027 enable=1 after a drop SHALL restart at index 0 with a fresh snapshot.
REQ-028 Slot and blank counters SHALL be 16 bits wide, SHALL count down, and SHALL reload on each state entry.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, index=0, counters=0, snapshot=0, com=8'hFF, seg=0, dp_out=0 and frame_done=0.
REQ-030 Release of reset SHALL take effect at the first clk edge with reset=1; an enable sampled high at that edge SHALL start the scan per REQ-015.

Structure
REQ-031 A shared package SHALL hold the state encoding and the 16-entry seven-segment constant table.
REQ-032 Decoding SHALL be a combinational sub-module seg7_dec (4-bit code in, 7-bit seg out) instantiated once.
REQ-033 The design SHALL contain no other sub-modules and SHALL use clk as its only clock.

Verification
REQ-034 SCAN_DIV=8, BLANK_CYC=2, enable=1, dig_val=32'h76543210, dp_in=0 -> com walks FE,FF,FD,FF,...,7F,FF with 6 drive cycles and 2 blank cycles per slot; seg per digit matches the table.
REQ-035 Same setup, dp_in=8'h01 rotated left once per frame -> dp_out=1 only during the DRIVE of the matching index.
REQ-036 lz_en=1, dig_val=32'h00000050 -> digits 7..2 seg=0; digit 1 shows 5; digit 0 shows 0.
REQ-037 dig_val changed mid-frame during index 3 -> indexes 4-7 show old data; new data appears from index 0 of the next frame; frame_done pulses once per frame.
REQ-038 enable dropped during DRIVE of index 5 -> next cycle com=FF, seg=0; re-enable -> com=FE on the following cycle.
REQ-039 reset asserted mid-BLANK, asynchronous to clk -> outputs reach reset values immediately; after release the scan starts at index 0.
